// File: rtl/mac_pipe_if.sv
// Term/result handshake bundle for mac_pipe: a valid/ready term stream in and a
// valid/ready result stream out. The master is the producer of terms and the consumer of results.
interface mac_pipe_if #(
  parameter int A_W   = 8,
  parameter int B_W   = 18,
  parameter int OUT_W = 26,
  parameter int CNT_W = 10
);
  logic             in_valid;
  logic             in_ready;
  logic             in_first;
  logic             in_last;
  logic [A_W-1:0]   a;
  logic [B_W-1:0]   b;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [CNT_W-1:0] out_cnt;
  logic             out_sat;

  modport master (
    output in_valid, in_first, in_last, a, b, out_ready,
    input  in_ready, out_valid, out_data, out_cnt, out_sat
  );

  modport slave (
    input  in_valid, in_first, in_last, a, b, out_ready,
    output in_ready, out_valid, out_data, out_cnt, out_sat
  );
endinterface

// File: rtl/mac_pipe.sv
// Pipelined multiply-accumulate over first..last delimited term vectors, one result per vector.
// Optional output clamping is enabled by defining MAC_SAT_EN; otherwise the result wraps to OUT_W bits.
module mac_pipe #(
  parameter int A_W      = 8,
  parameter int B_W      = 18,
  parameter int A_SIGNED = 0,
  parameter int B_SIGNED = 1,
  parameter int ACC_W    = 40,
  parameter int SHIFT    = 0,
  parameter int OUT_W    = 26,
  parameter int CNT_W    = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ce_i,
  mac_pipe_if.slave   mac_bus
);
  localparam int PW = A_W + B_W;
  localparam bit RES_SIGNED = (A_SIGNED != 0) || (B_SIGNED != 0);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             adv;
  logic             s1_valid_q, s1_first_q, s1_last_q;
  logic [A_W-1:0]   s1_a_q;
  logic [B_W-1:0]   s1_b_q;
  logic             s2_valid_q, s2_first_q, s2_last_q;
  logic [PW-1:0]    s2_prod_q;
  logic             s3_valid_q, s3_first_q, s3_last_q;
  logic [PW-1:0]    s3_prod_q;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_base;
  logic             fresh_q;
  logic             out_valid_q;
  logic [OUT_W-1:0] out_data_q, fmt_data;
  logic [CNT_W-1:0] out_cnt_q;

  logic signed [A_W:0] a_ext;
  logic signed [B_W:0] b_ext;
  logic [PW-1:0]       prod_d;
  logic                restart;
  logic [ACC_W-1:0]    prod_ext, shifted;

  assign adv               = ce_i & (~out_valid_q | mac_bus.out_ready);
  assign mac_bus.in_ready  = adv & rst_n;
  assign mac_bus.out_valid = out_valid_q;
  assign mac_bus.out_data  = out_data_q;
  assign mac_bus.out_cnt   = out_cnt_q;

  // One extra sign bit per operand lets a single signed multiply cover every signedness mix.
  assign a_ext  = {(A_SIGNED != 0) && s1_a_q[A_W-1], s1_a_q};
  assign b_ext  = {(B_SIGNED != 0) && s1_b_q[B_W-1], s1_b_q};
  assign prod_d = PW'(a_ext) * PW'(b_ext);

  assign restart  = s3_first_q | fresh_q;
  assign prod_ext = RES_SIGNED ? ACC_W'($signed(s3_prod_q)) : ACC_W'(s3_prod_q);
  assign acc_d    = (restart ? '0 : acc_q) + prod_ext;
  assign cnt_base = restart ? '0 : cnt_q;
  assign cnt_d    = (cnt_base == CNT_MAX) ? CNT_MAX : cnt_base + CNT_W'(1);
  assign shifted  = RES_SIGNED ? ACC_W'($signed(acc_d) >>> SHIFT) : (acc_d >> SHIFT);

`ifdef MAC_SAT_EN
  logic out_sat_q, fmt_sat;

  always_comb begin
    fmt_data = shifted[OUT_W-1:0];
    fmt_sat  = 1'b0;
    if (RES_SIGNED) begin
      // In range only when every bit above the result sign bit matches it.
      if (!((&shifted[ACC_W-1:OUT_W-1]) || (~|shifted[ACC_W-1:OUT_W-1]))) begin
        fmt_sat  = 1'b1;
        fmt_data = {shifted[ACC_W-1], {(OUT_W-1){~shifted[ACC_W-1]}}};
      end
    end else if (|shifted[ACC_W-1:OUT_W]) begin
      fmt_sat  = 1'b1;
      fmt_data = '1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_sat_q <= 1'b0;
    end else if (adv && s3_valid_q && s3_last_q) begin
      out_sat_q <= fmt_sat;
    end
  end

  assign mac_bus.out_sat = out_sat_q;
`else
  assign fmt_data        = OUT_W'(shifted);
  assign mac_bus.out_sat = 1'b0;
`endif

  // Operand, product and product-pipe stages; the product pipe keeps the adder off the multiplier path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s2_valid_q <= 1'b0;
      s2_first_q <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_prod_q  <= '0;
      s3_valid_q <= 1'b0;
      s3_first_q <= 1'b0;
      s3_last_q  <= 1'b0;
      s3_prod_q  <= '0;
    end else if (adv) begin
      s1_valid_q <= mac_bus.in_valid;
      s1_first_q <= mac_bus.in_first;
      s1_last_q  <= mac_bus.in_last;
      s1_a_q     <= mac_bus.a;
      s1_b_q     <= mac_bus.b;
      s2_valid_q <= s1_valid_q;
      s2_first_q <= s1_first_q;
      s2_last_q  <= s1_last_q;
      s2_prod_q  <= prod_d;
      s3_valid_q <= s2_valid_q;
      s3_first_q <= s2_first_q;
      s3_last_q  <= s2_last_q;
      s3_prod_q  <= s2_prod_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      fresh_q     <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_cnt_q   <= '0;
    end else if (adv) begin
      if (s3_valid_q) begin
        acc_q   <= acc_d;
        cnt_q   <= cnt_d;
        fresh_q <= s3_last_q;
      end
      if (s3_valid_q && s3_last_q) begin
        out_valid_q <= 1'b1;
        out_data_q  <= fmt_data;
        out_cnt_q   <= cnt_d;
      end else if (out_valid_q) begin
        // adv with a pending result implies the consumer took it this cycle.
        out_valid_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mac_pipe.sv
// Directed and random bench for mac_pipe; results are predicted by an arithmetic model of the vector rules.
module tb_mac_pipe;
  localparam int A_W = 8, B_W = 18, OUT_W = 26, CNT_W = 10;
  localparam longint MOD = 64'sh100_0000_0000;

  typedef struct packed {
    logic [OUT_W-1:0] d;
    logic [CNT_W-1:0] c;
    logic             s;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ce = 1'b1;
  logic tb_ce = 1'b1;
  logic tb_ord = 1'b1;

  int chk_cnt = 0;
  int pass_cnt = 0;
  res_t exp_q[$];
  res_t got_q[$];
  longint m_acc;
  int m_cnt;
  bit m_fresh;
  bit accepted;
  bit ov_seen;

  mac_pipe_if #(.A_W(A_W), .B_W(B_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) bus ();

  mac_pipe dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ce_i    (ce),
    .mac_bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    chk_cnt++;
    assert (obs === expv) pass_cnt++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
  endtask

  function automatic res_t mk(input longint d, input int c, input bit s);
    res_t r;
    r.d = d[OUT_W-1:0];
    r.c = c[CNT_W-1:0];
    r.s = s;
    return r;
  endfunction

  function automatic logic [63:0] r2v(input res_t r);
    return 64'(r);
  endfunction

  task automatic model_reset();
    m_acc = 0;
    m_cnt = 0;
    m_fresh = 1'b1;
    exp_q.delete();
  endtask

  // Vector rules: restart on first or after a last, sum wraps at 40 bits, count saturates.
  task automatic model_accept(input bit f, input bit l, input logic [A_W-1:0] a, input logic [B_W-1:0] b);
    longint p, s, lim;
    p = longint'(a) * longint'($signed(b));
    if (f || m_fresh) begin
      m_acc = 0;
      m_cnt = 0;
    end
    m_acc = (m_acc + p) & (MOD - 1);
    m_cnt = (m_cnt < 1023) ? m_cnt + 1 : 1023;
    m_fresh = 1'b0;
    if (l) begin
      s = (m_acc >= MOD / 2) ? m_acc - MOD : m_acc;
      lim = 64'sd1 <<< (OUT_W - 1);
`ifdef MAC_SAT_EN
      if (s > lim - 1)   exp_q.push_back(mk(lim - 1, m_cnt, 1'b1));
      else if (s < -lim) exp_q.push_back(mk(-lim, m_cnt, 1'b1));
      else               exp_q.push_back(mk(s, m_cnt, 1'b0));
`else
      if (lim != 0) exp_q.push_back(mk(s, m_cnt, 1'b0));
`endif
      m_fresh = 1'b1;
    end
  endtask

  task automatic step(input bit v, input bit f, input bit l, input logic [A_W-1:0] a, input logic [B_W-1:0] b);
    res_t g;
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_first  = f;
    bus.in_last   = l;
    bus.a         = a;
    bus.b         = b;
    bus.out_ready = tb_ord;
    ce            = tb_ce;
    #1;
    accepted = v && bus.in_ready;
    ov_seen  = bus.out_valid;
    if (tb_ce && bus.out_valid && tb_ord) begin
      g = {bus.out_data, bus.out_cnt, bus.out_sat};
      got_q.push_back(g);
      $display("result data=%0d cnt=%0d sat=%0d", $signed(g.d), g.c, g.s);
      check("result_expected", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) check("result", r2v(g), r2v(exp_q.pop_front()));
    end
    if (accepted) model_accept(f, l, a, b);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic send_beat(input bit f, input bit l, input logic [A_W-1:0] a, input logic [B_W-1:0] b);
    int n = 0;
    do begin
      step(1'b1, f, l, a, b);
      n++;
    end while (!accepted && n < 64);
    check("beat_accepted", 64'(accepted), 64'd1);
  endtask

  task automatic drain();
    int n = 0;
    tb_ord = 1'b1;
    tb_ce  = 1'b1;
    while (exp_q.size() != 0 && n < 80) begin
      idle(1);
      n++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    check("rst_out_data", 64'(bus.out_data), 64'd0);
    check("rst_out_cnt", 64'(bus.out_cnt), 64'd0);
    check("rst_out_sat", 64'(bus.out_sat), 64'd0);
    rst_n = 1'b1;
    model_reset();
    got_q.delete();
  endtask

  initial begin
    int first_i;
    bus.in_valid = 1'b0; bus.in_first = 1'b0; bus.in_last = 1'b0;
    bus.a = '0; bus.b = '0; bus.out_ready = 1'b1;
    model_reset();
    do_reset();

    // 1: single-beat vector, latency and value
    send_beat(1'b1, 1'b1, 8'd255, 18'(-131072));
    first_i = 0;
    for (int i = 1; i <= 8; i++) begin
      idle(1);
      if (ov_seen && first_i == 0) first_i = i;
    end
    check("t1_latency", 64'(first_i), 64'd4);
    check("t1_count", 64'(got_q.size()), 64'd1);
    check("t1_value", r2v(got_q[0]), r2v(mk(-33423360, 1, 1'b0)));

    // 2: four-term vector then a vector lacking first
    got_q.delete();
    for (int i = 1; i <= 4; i++) send_beat(i == 1, i == 4, 8'(i), 18'd10);
    send_beat(1'b0, 1'b1, 8'd2, 18'd5);
    drain();
    check("t2_v1", r2v(got_q[0]), r2v(mk(100, 4, 1'b0)));
    check("t2_v2", r2v(got_q[1]), r2v(mk(10, 1, 1'b0)));

    // 3: back-pressure holds output and stalls input
    got_q.delete();
    tb_ord = 1'b0;
    for (int i = 1; i <= 4; i++) send_beat(i == 1, i == 4, 8'(i), 18'd10);
    send_beat(1'b0, 1'b1, 8'd2, 18'd5);
    first_i = 0;
    while (!ov_seen && first_i < 20) begin
      idle(1);
      first_i++;
    end
    for (int i = 0; i < 10; i++) begin
      idle(1);
      check("t3_in_ready", 64'(bus.in_ready), 64'd0);
      check("t3_hold", 64'(bus.out_data), 64'd100);
    end
    drain();
    check("t3_n", 64'(got_q.size()), 64'd2);
    check("t3_v1", r2v(got_q[0]), r2v(mk(100, 4, 1'b0)));
    check("t3_v2", r2v(got_q[1]), r2v(mk(10, 1, 1'b0)));

    // 4: clock enable low mid-vector
    got_q.delete();
    send_beat(1'b1, 1'b0, 8'd1, 18'd10);
    send_beat(1'b0, 1'b0, 8'd2, 18'd10);
    tb_ce = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b0, 8'd99, 18'd99);
      check("t4_ce_in_ready", 64'(bus.in_ready), 64'd0);
    end
    tb_ce = 1'b1;
    send_beat(1'b0, 1'b0, 8'd3, 18'd10);
    send_beat(1'b0, 1'b1, 8'd4, 18'd10);
    drain();
    check("t4_value", r2v(got_q[0]), r2v(mk(100, 4, 1'b0)));

    // 5: overflow beyond OUT_W
    got_q.delete();
    send_beat(1'b1, 1'b0, 8'd255, 18'd131071);
    send_beat(1'b0, 1'b1, 8'd255, 18'd131071);
    drain();
`ifdef MAC_SAT_EN
    check("t5_value", r2v(got_q[0]), r2v(mk(33554431, 2, 1'b1)));
`else
    check("t5_value", r2v(got_q[0]), r2v(mk(-262654, 2, 1'b0)));
`endif

    // 6: reset discards a partial vector
    send_beat(1'b1, 1'b0, 8'd5, 18'd9);
    send_beat(1'b0, 1'b0, 8'd6, 18'd9);
    do_reset();
    send_beat(1'b0, 1'b1, 8'd3, 18'(-7));
    drain();
    idle(10);
    check("t6_n", 64'(got_q.size()), 64'd1);
    check("t6_value", r2v(got_q[0]), r2v(mk(-21, 1, 1'b0)));

    // 7: term counter saturation
    got_q.delete();
    for (int i = 0; i < 1030; i++) send_beat(i == 0, i == 1029, 8'd1, 18'd1);
    drain();
    check("t7_value", r2v(got_q[0]), r2v(mk(1030, 1023, 1'b0)));

    // 8: random traffic against the model
    for (int i = 0; i < 600; i++) begin
      tb_ord = ($urandom_range(0, 9) < 7);
      tb_ce  = ($urandom_range(0, 9) != 0);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0,
           8'($urandom), 18'($urandom));
    end
    drain();
    idle(6);
    check("t8_no_extra", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
